// File: rtl/freq_meter_pkg.sv
// Shared types and defaults for the frequency/duty meter.
package freq_meter_pkg;

    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_e;

endpackage

// File: rtl/freq_meter_sync.sv
// Two-flop synchronizer for sig_in plus rise/fall strobes taken from stage 2
// against a third registered copy.
module freq_meter_sync (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic sig_sync,
    output logic rise,
    output logic fall
);

    logic s1_q, s2_q, s3_q;
    logic s1_d, s2_d, s3_d;

    always_comb begin
        s1_d = sig_in;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    // Strobes are combinational so the FSM acts on them at the third edge.
    assign sig_sync = s2_q;
    assign rise     = s2_q & ~s3_q;
    assign fall     = ~s2_q & s3_q;

endmodule

// File: rtl/freq_meter.sv
// Measures period and high time of a slow signal in clk cycles, with a sticky
// timeout when no rising edge arrives within TIMEOUT cycles.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TIMEOUT = 2**CNT_W - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             timeout,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(TIMEOUT);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (x == CNT_MAX) ? x : x + CNT_ONE;
    endfunction

    logic sig_sync, rise, fall;

    freq_meter_sync u_sync (
        .clk     (clk),
        .rst     (rst),
        .sig_in  (sig_in),
        .sig_sync(sig_sync),
        .rise    (rise),
        .fall    (fall)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
    logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;

    always_comb begin
        state_d   = state_q;
        per_cnt_d = per_cnt_q;
        hi_cnt_d  = hi_cnt_q;
        period_d  = period_q;
        high_d    = high_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;

        // Dropping en discards any partial measurement, ahead of rise/timeout.
        if (!en) begin
            state_d   = IDLE;
            per_cnt_d = '0;
            hi_cnt_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d   = ARM;
                    per_cnt_d = '0;
                    hi_cnt_d  = '0;
                end
                ARM: begin
                    if (rise) begin
                        state_d   = MEASURE;
                        per_cnt_d = CNT_ONE;
                        hi_cnt_d  = CNT_ONE;
                    end else if (per_cnt_q >= TO_LIM) begin
                        timeout_d = 1'b1;
                        per_cnt_d = '0;
                        hi_cnt_d  = '0;
                    end else begin
                        per_cnt_d = sat_inc(per_cnt_q);
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        // Close this period and start the next one with no gap.
                        period_d  = per_cnt_q;
                        high_d    = hi_cnt_q;
                        valid_d   = 1'b1;
                        timeout_d = 1'b0;
                        per_cnt_d = CNT_ONE;
                        hi_cnt_d  = CNT_ONE;
                    end else if (per_cnt_q >= TO_LIM) begin
                        state_d   = ARM;
                        timeout_d = 1'b1;
                        per_cnt_d = '0;
                        hi_cnt_d  = '0;
                    end else begin
                        per_cnt_d = sat_inc(per_cnt_q);
                        if (sig_sync && !fall) begin
                            hi_cnt_d = sat_inc(hi_cnt_q);
                        end
                    end
                end
                default: begin
                    state_d   = IDLE;
                    per_cnt_d = '0;
                    hi_cnt_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            per_cnt_q <= '0;
            hi_cnt_q  <= '0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            per_cnt_q <= per_cnt_d;
            hi_cnt_q  <= hi_cnt_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign period     = period_q;
    assign high_time  = high_q;
    assign meas_valid = valid_q;
    assign timeout    = timeout_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_freq_meter.sv
// Scoreboard bench for freq_meter: a 16-bit instance with TIMEOUT=20 and a
// 4-bit instance for saturation/timeout boundaries.
module tb_freq_meter;

    logic        clk = 1'b0;
    logic        rst, en, sig, en4, sig4;
    logic [15:0] period, high_time;
    logic        meas_valid, timeout, busy;
    logic [3:0]  period4, high_time4;
    logic        meas_valid4, timeout4, busy4;

    always #5 clk = ~clk;

    freq_meter #(.CNT_W(16), .TIMEOUT(20)) u_dut (
        .clk(clk), .rst(rst), .en(en), .sig_in(sig),
        .period(period), .high_time(high_time), .meas_valid(meas_valid),
        .timeout(timeout), .busy(busy)
    );

    freq_meter #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .en(en4), .sig_in(sig4),
        .period(period4), .high_time(high_time4), .meas_valid(meas_valid4),
        .timeout(timeout4), .busy(busy4)
    );

    typedef struct {
        int per;
        int hi;
        int gap;  // cycles since previous meas_valid, 0 = unchecked
    } exp_t;

    exp_t q1[$];
    exp_t q4[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push1(input int p, input int h, input int g);
        exp_t e;
        e.per = p; e.hi = h; e.gap = g;
        q1.push_back(e);
    endtask

    task automatic push4(input int p, input int h, input int g);
        exp_t e;
        e.per = p; e.hi = h; e.gap = g;
        q4.push_back(e);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wave(input int hi, input int lo, input int n);
        for (int i = 0; i < n; i++) begin
            sig = 1'b1; cyc(hi);
            sig = 1'b0; cyc(lo);
        end
    endtask

    task automatic wave4(input int hi, input int lo, input int n);
        for (int i = 0; i < n; i++) begin
            sig4 = 1'b1; cyc(hi);
            sig4 = 1'b0; cyc(lo);
        end
    endtask

    // Monitor: pops the scoreboard whenever either DUT presents meas_valid.
    initial begin
        int   ncyc, last1, last4;
        logic pv1, pv4;
        exp_t e;
        ncyc = 0; last1 = 0; last4 = 0; pv1 = 1'b0; pv4 = 1'b0;
        forever begin
            @(negedge clk);
            ncyc++;
            if (meas_valid === 1'b1) begin
                chk("valid_width", pv1, 0);
                chk("timeout_on_valid", timeout, 0);
                if (q1.size() == 0) begin
                    chk("unexpected_valid", meas_valid, 0);
                end else begin
                    e = q1.pop_front();
                    chk("period", period, e.per);
                    chk("high_time", high_time, e.hi);
                    if (e.gap != 0) chk("valid_gap", ncyc - last1, e.gap);
                end
                last1 = ncyc;
            end
            pv1 = meas_valid;
            if (meas_valid4 === 1'b1) begin
                chk("valid_width4", pv4, 0);
                if (q4.size() == 0) begin
                    chk("unexpected_valid4", meas_valid4, 0);
                end else begin
                    e = q4.pop_front();
                    chk("period4", period4, e.per);
                    chk("high_time4", high_time4, e.hi);
                    if (e.gap != 0) chk("valid_gap4", ncyc - last4, e.gap);
                end
                last4 = ncyc;
            end
            pv4 = meas_valid4;
        end
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        rst = 1'b1; en = 1'b0; sig = 1'b0; en4 = 1'b0; sig4 = 1'b0;
        cyc(3);
        chk("rst_period", period, 0);
        chk("rst_high_time", high_time, 0);
        chk("rst_meas_valid", meas_valid, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout4", timeout4, 0);
        en = 1'b1;                      // reset must win over en
        cyc(2);
        chk("rst_over_en_busy", busy, 0);
        en = 1'b0; rst = 1'b0;
        cyc(2);
        chk("idle_busy", busy, 0);

        // Divide-by-4, 2 high / 2 low
        push1(4, 2, 0);
        for (int i = 0; i < 4; i++) push1(4, 2, 4);
        en = 1'b1; cyc(2);
        chk("arm_busy", busy, 1);
        wave(2, 2, 6);
        cyc(3); en = 1'b0; cyc(2);
        chk("div4_drained", q1.size(), 0);

        // 7-cycle period, 3 high / 4 low
        push1(7, 3, 0);
        for (int i = 0; i < 3; i++) push1(7, 3, 7);
        en = 1'b1; cyc(2);
        wave(3, 4, 5);
        cyc(3); en = 1'b0; cyc(2);
        chk("p7_drained", q1.size(), 0);

        // Timeout: sig held low, then resumes as divide-by-4
        en = 1'b1; sig = 1'b0;
        cyc(10);
        chk("timeout_early", timeout, 0);
        cyc(15);
        chk("timeout_set", timeout, 1);
        en = 1'b0; cyc(1);
        chk("timeout_sticky_en", timeout, 1);
        chk("en_low_busy", busy, 0);
        en = 1'b1;
        push1(4, 2, 0);
        push1(4, 2, 4);
        push1(4, 2, 4);
        cyc(1);
        wave(2, 2, 4);
        cyc(3);
        chk("timeout_cleared", timeout, 0);
        en = 1'b0; cyc(2);
        chk("timeout_drained", q1.size(), 0);

        // en dropped for one cycle mid-MEASURE discards the partial period
        push1(4, 2, 0); push1(4, 2, 4);
        push1(4, 2, 0); push1(4, 2, 4);
        en = 1'b1; cyc(2);
        wave(2, 2, 3);
        cyc(3);
        en = 1'b0; cyc(1);
        chk("en_drop_busy", busy, 0);
        en = 1'b1; cyc(1);
        chk("reenable_busy", busy, 1);
        cyc(1);
        wave(2, 2, 3);
        cyc(3); en = 1'b0; cyc(2);
        chk("en_drop_drained", q1.size(), 0);

        // Reset pulse mid-measurement with en held high
        push1(4, 2, 0); push1(4, 2, 4);
        push1(4, 2, 0); push1(4, 2, 4);
        en = 1'b1; cyc(2);
        wave(2, 2, 3);
        cyc(1);
        rst = 1'b1; cyc(1);
        chk("midrst_period", period, 0);
        chk("midrst_high_time", high_time, 0);
        chk("midrst_meas_valid", meas_valid, 0);
        chk("midrst_timeout", timeout, 0);
        chk("midrst_busy", busy, 0);
        rst = 1'b0; cyc(2);
        wave(2, 2, 3);
        cyc(3); en = 1'b0; cyc(2);
        chk("rst_drained", q1.size(), 0);

        // Sub-cycle glitch between sampling edges while measuring
        push1(4, 2, 0);
        en = 1'b1; cyc(2);
        wave(2, 2, 2);
        cyc(2);
        sig = 1'b1; #2; sig = 1'b0;
        cyc(8);
        en = 1'b0; cyc(2);
        chk("glitch_drained", q1.size(), 0);

        // CNT_W=4: period 15 is the largest measurable, longer must not wrap
        push4(15, 8, 0); push4(15, 8, 15);
        en4 = 1'b1; cyc(2);
        wave4(8, 7, 3);
        cyc(6);
        chk("sat_drained", q4.size(), 0);
        chk("sat_timeout_low", timeout4, 1);
        sig4 = 1'b1;
        cyc(40);
        chk("stuck_high_period4", period4, 15);
        chk("stuck_high_high4", high_time4, 8);
        chk("stuck_high_timeout4", timeout4, 1);
        en4 = 1'b0; sig4 = 1'b0; cyc(2);
        en4 = 1'b1; cyc(2);
        wave4(8, 8, 3);
        cyc(4);
        chk("p16_timeout4", timeout4, 1);
        chk("p16_period4", period4, 15);
        en4 = 1'b0; cyc(2);
        chk("p16_drained", q4.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
